// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle core: FSM states, writeback selects, opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   // writeback mux select codes
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_UI   = 2'd3;

   // RV32I major opcodes, shared with the decoder
   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;
   localparam logic [6:0] OP_JALR   = 7'b110_0111;
   localparam logic [6:0] OP_IMM    = 7'b001_0011;
   localparam logic [6:0] OP_REG    = 7'b011_0011;
   localparam logic [6:0] OP_LUI    = 7'b011_0111;
   localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

   // instruction addresses must be word aligned
   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: counts stalled cycles and flags when the limit value is reached.
// Latency: count updates one cycle after en; at_limit is a combinational compare of count.
// Backpressure: none; the counter saturates at LIMIT and holds until cleared.
module ctrl_wait_cnt #(
   parameter int W     = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic at_limit
);

   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] count;

   assign at_limit = (count == LIMIT_V);

   // count stalled cycles, never wrapping past the limit
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (en && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I sequencer: owns the pc, runs the imem/dmem handshakes, steers writeback.
// Latency (zero-wait memory): alu/ui/jump 4 cycles, branch 3, store 4, load 5.
// Backpressure: FETCH/MEM stall on !ready; TIMEOUT stalled cycles with no ready at the limit traps.
module core_ctrl
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          TIMEOUT   = 255,
   parameter int          TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        instr_en,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_ui,
   input  logic        add_pc,
   input  logic        is_branch,
   input  logic        is_jump,
   input  logic        is_reg,
   input  logic        is_alu,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic [31:0] jump_target,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        trap,
   output logic [2:0]  state
);

   state_t      cur;
   logic [31:0] tgt_q;      // jump target carried from EXEC to WB
   logic        jump_q;     // WB loads tgt_q instead of pc + 4
   logic        store_q;    // MEM access direction
   logic [1:0]  wb_sel_q;
   logic        waiting;
   logic        at_limit;
   logic [31:0] jmp_tgt;
   logic [31:0] br_tgt;

   assign pc_plus4 = pc + 32'd4;
   // jalr clears bit 0; the result is still checked for word alignment below
   assign jmp_tgt  = is_reg ? {jump_target[31:1], 1'b0} : jump_target;
   assign br_tgt   = pc + branch_offset;

   // stalled cycle in either handshake state; any other cycle clears the counter,
   // so the count is zero on every entry to FETCH or MEM
   assign waiting = ((cur == FETCH) && !imem_ready) || ((cur == MEM) && !dmem_ready);

   ctrl_wait_cnt #(
      .W     (TIMEOUT_W),
      .LIMIT (TIMEOUT)
   ) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (!waiting),
      .en       (waiting),
      .at_limit (at_limit)
   );

   assign imem_req = (cur == FETCH);
   assign instr_en = (cur == FETCH) && imem_ready;
   assign dmem_req = (cur == MEM);
   assign dmem_we  = store_q;
   assign rf_we    = (cur == WB);
   assign wb_sel   = wb_sel_q;
   assign trap     = (cur == TRAP);
   assign state    = cur;

   // sequencer: state, pc and the values latched in EXEC for MEM/WB
   always_ff @(posedge clk) begin
      if (reset) begin
         cur      <= FETCH;
         pc       <= RESET_PC;
         tgt_q    <= '0;
         jump_q   <= 1'b0;
         store_q  <= 1'b0;
         wb_sel_q <= WB_ALU;
      end else begin
         case (cur)
            FETCH: begin
               // ready wins over the limit in the same cycle
               if (imem_ready)    cur <= DECODE;
               else if (at_limit) cur <= TRAP;
            end
            DECODE: cur <= EXEC;
            EXEC: begin
               if (is_load) begin
                  store_q <= 1'b0;
                  jump_q  <= 1'b0;
                  cur     <= MEM;
               end else if (is_store) begin
                  store_q <= 1'b1;
                  cur     <= MEM;
               end else if (is_jump) begin
                  if (misaligned(jmp_tgt)) begin
                     cur <= TRAP;
                  end else begin
                     tgt_q    <= jmp_tgt;
                     jump_q   <= 1'b1;
                     wb_sel_q <= WB_PC4;
                     cur      <= WB;
                  end
               end else if (is_branch) begin
                  if (!branch_taken) begin
                     pc  <= pc_plus4;
                     cur <= FETCH;
                  end else if (misaligned(br_tgt)) begin
                     cur <= TRAP;
                  end else begin
                     pc  <= br_tgt;
                     cur <= FETCH;
                  end
               end else if (is_alu) begin
                  jump_q   <= 1'b0;
                  wb_sel_q <= WB_ALU;
                  cur      <= WB;
               end else if (is_ui) begin
                  jump_q   <= 1'b0;
                  wb_sel_q <= WB_UI;
                  cur      <= WB;
               end else if (add_pc) begin
                  // pc-relative sum without is_ui arrives through the ALU result
                  jump_q   <= 1'b0;
                  wb_sel_q <= WB_ALU;
                  cur      <= WB;
               end else begin
                  cur <= TRAP;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  if (store_q) begin
                     pc  <= pc_plus4;
                     cur <= FETCH;
                  end else begin
                     wb_sel_q <= WB_LOAD;
                     cur      <= WB;
                  end
               end else if (at_limit) begin
                  cur <= TRAP;
               end
            end
            WB: begin
               pc  <= jump_q ? tgt_q : pc_plus4;
               cur <= FETCH;
            end
            TRAP:    cur <= TRAP;
            default: cur <= TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: instruction-level model builds a per-cycle expectation.
// Latency: expectations set 1 time unit after posedge, compared on negedge.
// Backpressure: imem/dmem ready patterns come from each test vector.
module tb_core_ctrl;
   import core_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TIMEOUT  = 255;

   typedef enum {K_ALU, K_UI, K_JAL, K_JALR, K_BR, K_LOAD, K_STORE, K_BAD} kind_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        is_load = 1'b0, is_store = 1'b0, is_ui = 1'b0, add_pc = 1'b0;
   logic        is_branch = 1'b0, is_jump = 1'b0, is_reg = 1'b0, is_alu = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = '0, jump_target = '0;
   logic        imem_req, instr_en, dmem_req, dmem_we, rf_we, trap;
   logic [1:0]  wb_sel;
   logic [31:0] pc, pc_plus4;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: architectural pc and halt flag
   logic [31:0] m_pc = RESET_PC;
   bit          m_trap = 1'b0;

   // expectation for the current cycle
   bit          e_vld = 1'b0;
   logic [2:0]  e_st;
   logic        e_ireq, e_ien, e_dreq, e_dwe, e_rfwe;
   logic [1:0]  e_wbs;
   logic [31:0] e_pc;

   core_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_ready(imem_ready), .instr_en(instr_en),
      .is_load(is_load), .is_store(is_store), .is_ui(is_ui), .add_pc(add_pc),
      .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
      .branch_taken(branch_taken), .branch_offset(branch_offset), .jump_target(jump_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc), .pc_plus4(pc_plus4),
      .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // single compare process: every modelled cycle is checked away from the edge
   always @(negedge clk) begin
      if (e_vld) begin
         chk32("state", 32'(state), 32'(e_st));
         chk32("pc", pc, e_pc);
         chk32("pc_plus4", pc_plus4, e_pc + 32'd4);
         chkb("imem_req", imem_req, e_ireq);
         chkb("instr_en", instr_en, e_ien);
         chkb("dmem_req", dmem_req, e_dreq);
         chkb("rf_we", rf_we, e_rfwe);
         chkb("trap", trap, e_st == 3'(TRAP));
         if (e_dreq) chkb("dmem_we", dmem_we, e_dwe);
         if (e_rfwe) chk32("wb_sel", 32'(wb_sel), 32'(e_wbs));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cyc(input state_t st, input logic ireq, input logic ien, input logic dreq,
                             input logic dwe, input logic rfwe, input logic [1:0] wbs);
      e_st = st; e_ireq = ireq; e_ien = ien; e_dreq = dreq;
      e_dwe = dwe; e_rfwe = rfwe; e_wbs = wbs; e_pc = m_pc; e_vld = 1'b1;
   endtask

   task automatic clear_flags();
      is_load = 0; is_store = 0; is_ui = 0; add_pc = 0;
      is_branch = 0; is_jump = 0; is_reg = 0; is_alu = 0; branch_taken = 0;
   endtask

   task automatic do_reset();
      e_vld = 1'b0;
      reset = 1'b1;
      clear_flags();
      imem_ready = 0; dmem_ready = 0;
      step();
      step();
      reset = 1'b0;
      m_pc = RESET_PC;
      m_trap = 1'b0;
   endtask

   // handshake phase: ready arrives after 'waits' stalled cycles; more than TIMEOUT stalls traps
   task automatic wait_phase(input bit mem, input bit we, input int waits, output bit trapped);
      for (int k = 0; k <= TIMEOUT; k++) begin
         if (mem) begin
            dmem_ready = (k == waits);
            expect_cyc(MEM, 0, 0, 1, we, 0, 2'd0);
         end else begin
            imem_ready = (k == waits);
            expect_cyc(FETCH, 1, (k == waits), 0, 0, 0, 2'd0);
         end
         step();
         if (k == waits) break;
      end
      imem_ready = 0;
      dmem_ready = 0;
      trapped = (waits > TIMEOUT);
      if (trapped) m_trap = 1'b1;
   endtask

   task automatic wb_phase(input logic [1:0] sel, input logic [31:0] nxt);
      expect_cyc(WB, 0, 0, 0, 0, 1, sel);
      step();
      m_pc = nxt;
   endtask

   task automatic expect_trap(input int n);
      imem_ready = 1; dmem_ready = 1;
      for (int i = 0; i < n; i++) begin
         expect_cyc(TRAP, 0, 0, 0, 0, 0, 2'd0);
         step();
      end
      imem_ready = 0; dmem_ready = 0;
   endtask

   // one instruction at the architectural level: pc/trap result from the ISA rules
   task automatic run_instr(input kind_t k, input logic taken, input logic [31:0] val,
                            input int fw, input int mw);
      bit          tr;
      logic [31:0] t;
      wait_phase(0, 0, fw, tr);
      if (!tr) begin
         expect_cyc(DECODE, 0, 0, 0, 0, 0, 2'd0);
         step();
         case (k)
            K_ALU:   is_alu = 1;
            K_UI:    is_ui = 1;
            K_JAL:   is_jump = 1;
            K_JALR:  begin is_jump = 1; is_reg = 1; end
            K_BR:    is_branch = 1;
            K_LOAD:  is_load = 1;
            K_STORE: is_store = 1;
            default: ;
         endcase
         branch_taken = taken;
         branch_offset = val;
         jump_target = val;
         expect_cyc(EXEC, 0, 0, 0, 0, 0, 2'd0);
         step();
         clear_flags();
         case (k)
            K_ALU: wb_phase(WB_ALU, m_pc + 32'd4);
            K_UI:  wb_phase(WB_UI, m_pc + 32'd4);
            K_JAL, K_JALR: begin
               t = val;
               if (k == K_JALR) t[0] = 1'b0;
               if (t % 4 != 0) m_trap = 1'b1;
               else wb_phase(WB_PC4, t);
            end
            K_BR: begin
               t = taken ? m_pc + val : m_pc + 32'd4;
               if (t % 4 != 0) m_trap = 1'b1;
               else m_pc = t;
            end
            K_LOAD: begin
               wait_phase(1, 0, mw, tr);
               if (!tr) wb_phase(WB_LOAD, m_pc + 32'd4);
            end
            K_STORE: begin
               wait_phase(1, 1, mw, tr);
               if (!tr) m_pc = m_pc + 32'd4;
            end
            default: m_trap = 1'b1;
         endcase
      end
      if (m_trap) expect_trap(2);
   endtask

   initial begin
      bit tr;
      do_reset();
      chk32("rst_state", 32'(state), 32'(FETCH));
      chk32("rst_pc", pc, 32'h0);
      chkb("rst_trap", trap, 1'b0);
      chkb("rst_rf_we", rf_we, 1'b0);
      chkb("rst_dmem_req", dmem_req, 1'b0);

      run_instr(K_ALU, 0, 32'h0, 0, 0);
      chk32("addi_pc", pc, 32'h4);
      run_instr(K_UI, 0, 32'h0, 1, 0);
      chk32("lui_pc", pc, 32'h8);
      run_instr(K_JAL, 0, 32'h100, 0, 0);
      chk32("jal_pc", pc, 32'h100);
      run_instr(K_BR, 1, 32'hFFFF_FFF8, 0, 0);
      chk32("br_taken_pc", pc, 32'hF8);
      run_instr(K_JAL, 0, 32'h100, 0, 0);
      run_instr(K_BR, 0, 32'hFFFF_FFF8, 0, 0);
      chk32("br_not_taken_pc", pc, 32'h104);
      run_instr(K_JALR, 0, 32'h205, 0, 0);
      chk32("jalr_pc", pc, 32'h204);
      run_instr(K_LOAD, 0, 32'h0, 2, 3);
      chk32("load_pc", pc, 32'h208);
      run_instr(K_STORE, 0, 32'h0, 0, 0);
      chk32("store_pc", pc, 32'h20C);
      run_instr(K_JALR, 0, 32'h203, 0, 0);
      chkb("jalr_mis_trap", trap, 1'b1);
      chk32("jalr_mis_pc", pc, 32'h20C);

      do_reset();
      run_instr(K_JAL, 0, 32'h102, 0, 0);
      chkb("jal_mis_trap", trap, 1'b1);
      chk32("jal_mis_pc", pc, 32'h0);

      do_reset();
      run_instr(K_BR, 1, 32'h6, 0, 0);
      chkb("br_mis_trap", trap, 1'b1);

      do_reset();
      run_instr(K_ALU, 0, 32'h0, TIMEOUT + 1, 0);
      chkb("imem_timeout_trap", trap, 1'b1);

      do_reset();
      run_instr(K_ALU, 0, 32'h0, TIMEOUT, 0);
      chk32("imem_limit_pc", pc, 32'h4);
      run_instr(K_STORE, 0, 32'h0, 0, TIMEOUT + 1);
      chkb("dmem_timeout_trap", trap, 1'b1);
      chk32("dmem_timeout_pc", pc, 32'h4);

      // reset while a load is stalled in MEM
      do_reset();
      run_instr(K_ALU, 0, 32'h0, 0, 0);
      wait_phase(0, 0, 0, tr);
      expect_cyc(DECODE, 0, 0, 0, 0, 0, 2'd0);
      step();
      is_load = 1;
      expect_cyc(EXEC, 0, 0, 0, 0, 0, 2'd0);
      step();
      clear_flags();
      expect_cyc(MEM, 0, 0, 1, 0, 0, 2'd0);
      step();
      reset = 1'b1;
      expect_cyc(MEM, 0, 0, 1, 0, 0, 2'd0);
      step();
      reset = 1'b0;
      m_pc = RESET_PC;
      chk32("mem_rst_state", 32'(state), 32'(FETCH));
      chk32("mem_rst_pc", pc, 32'h0);
      chkb("mem_rst_dmem_req", dmem_req, 1'b0);

      // unknown opcode halts until reset, regardless of memory readies
      run_instr(K_BAD, 0, 32'h0, 0, 0);
      expect_trap(5);
      chkb("bad_trap_sticky", trap, 1'b1);
      chk32("bad_trap_pc", pc, 32'h0);
      do_reset();
      chkb("bad_trap_cleared", trap, 1'b0);
      run_instr(K_ALU, 0, 32'h0, 0, 0);
      chk32("post_trap_pc", pc, 32'h4);

      e_vld = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
